// File: rtl/bounce_sprite_engine.sv
// Bouncing square sprites: one-sprite-per-cycle position sweep on frame_tick,
// plus fixed-priority compositing into a registered 6-bit colour.
module bounce_sprite_engine #(
   parameter int unsigned NUM_SPRITES   = 4,
   parameter int unsigned SIZE          = 64,
   parameter int unsigned H_ACTIVE      = 640,
   parameter int unsigned V_ACTIVE      = 480,
   parameter int unsigned X_SPACING     = 80,
   parameter logic [47:0] SPRITE_COLORS = 48'h0000_00F0_3C0C
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       pause,
   input  logic [1:0] speed_sel,
   input  logic       display_on,
   input  logic [9:0] pix_x,
   input  logic [9:0] pix_y,
   output logic [5:0] pix_rgb,
   output logic       busy,
   output logic [7:0] bounce_count
);

   localparam int unsigned IDX_W  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
   localparam logic [10:0] X_LIM  = 11'(H_ACTIVE - SIZE);
   localparam logic [10:0] Y_LIM  = 11'(V_ACTIVE - SIZE);
   localparam logic [10:0] SIZE_W = 11'(SIZE);

   typedef enum logic {ST_IDLE, ST_UPDATE} state_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic                   busy_q, busy_d;
   logic [7:0]             bounce_q, bounce_d;
   logic [5:0]             rgb_q, rgb_d;
   logic [9:0]             x_q [NUM_SPRITES];
   logic [9:0]             x_d [NUM_SPRITES];
   logic [9:0]             y_q [NUM_SPRITES];
   logic [9:0]             y_d [NUM_SPRITES];
   logic [NUM_SPRITES-1:0] dx_q, dx_d;   // 1 = moving towards 0
   logic [NUM_SPRITES-1:0] dy_q, dy_d;
   logic [11:0]            mv_x, mv_y;   // {bounced, new_dir, new_pos}

   function automatic logic [10:0] base_vx(input int i);
      return 11'(2 + (i % 4));
   endfunction

   function automatic logic [10:0] base_vy(input int i);
      return 11'(1 + (i % 3));
   endfunction

   // One axis step with wall clamp; the walls are at 0 and lim.
   function automatic logic [11:0] axis_move(input logic [9:0] pos, input logic neg,
                                             input logic [10:0] step, input logic [10:0] lim);
      logic signed [10:0] np;
      logic [11:0]        res;
      if (!neg) begin
         np = $signed({1'b0, pos}) + $signed(step);
         if (np >= $signed(lim)) res = {2'b11, lim[9:0]};
         else                    res = {2'b00, np[9:0]};
      end else begin
         np = $signed({1'b0, pos}) - $signed(step);
         if (np <= 11'sd0) res = {2'b10, 10'd0};
         else              res = {2'b01, np[9:0]};
      end
      return res;
   endfunction

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      busy_d   = busy_q;
      bounce_d = bounce_q;
      x_d      = x_q;
      y_d      = y_q;
      dx_d     = dx_q;
      dy_d     = dy_q;
      mv_x     = '0;
      mv_y     = '0;
      case (state_q)
         ST_IDLE: begin
            if (frame_tick && !pause) begin
               state_d = ST_UPDATE;
               idx_d   = '0;
               busy_d  = 1'b1;
            end
         end
         ST_UPDATE: begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
               if (idx_q == IDX_W'(i)) begin
                  mv_x    = axis_move(x_q[i], dx_q[i], base_vx(i) << speed_sel, X_LIM);
                  mv_y    = axis_move(y_q[i], dy_q[i], base_vy(i) << speed_sel, Y_LIM);
                  x_d[i]  = mv_x[9:0];
                  dx_d[i] = mv_x[10];
                  y_d[i]  = mv_y[9:0];
                  dy_d[i] = mv_y[10];
               end
            end
            if (mv_x[11] || mv_y[11]) bounce_d = bounce_q + 8'd1;
            if (idx_q == IDX_W'(NUM_SPRITES - 1)) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
      endcase
   end

   // Compositing: iterate high to low so the lowest covering index wins.
   always_comb begin
      rgb_d = '0;
      if (display_on) begin
         for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (({1'b0, pix_x} >= {1'b0, x_q[i]}) && ({1'b0, pix_x} < ({1'b0, x_q[i]} + SIZE_W)) &&
                ({1'b0, pix_y} >= {1'b0, y_q[i]}) && ({1'b0, pix_y} < ({1'b0, y_q[i]} + SIZE_W)))
               rgb_d = SPRITE_COLORS[6*i +: 6];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         busy_q   <= 1'b0;
         bounce_q <= '0;
         rgb_q    <= '0;
         dx_q     <= '0;
         for (int i = 0; i < NUM_SPRITES; i++) begin
            x_q[i]  <= 10'(i * X_SPACING);
            y_q[i]  <= 10'(i * 32);
            dy_q[i] <= ((i % 2) == 1);
         end
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         busy_q   <= busy_d;
         bounce_q <= bounce_d;
         rgb_q    <= rgb_d;
         x_q      <= x_d;
         y_q      <= y_d;
         dx_q     <= dx_d;
         dy_q     <= dy_d;
      end
   end

   assign pix_rgb      = rgb_q;
   assign busy         = busy_q;
   assign bounce_count = bounce_q;

endmodule

// File: tb/tb_bounce_sprite_engine.sv
// Scoreboard bench for bounce_sprite_engine: a behavioural sprite model
// predicts colours, sweep length and bounce count.
module tb_bounce_sprite_engine;

   localparam int N  = 4;
   localparam int SZ = 64;
   localparam int HA = 640;
   localparam int VA = 480;
   localparam int XS = 80;
   localparam logic [47:0] COLS = 48'h0000_00F0_3C0C;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic       pause = 1'b0;
   logic [1:0] speed_sel = 2'd0;
   logic       display_on = 1'b0;
   logic [9:0] pix_x = '0;
   logic [9:0] pix_y = '0;
   logic [5:0] pix_rgb;
   logic       busy;
   logic [7:0] bounce_count;

   int tests = 0;
   int fails = 0;
   int mx[N], my[N], mdx[N], mdy[N];
   int mbounce;
   int exp_q[$];

   always #5 clk = ~clk;

   bounce_sprite_engine #(
      .NUM_SPRITES(N), .SIZE(SZ), .H_ACTIVE(HA), .V_ACTIVE(VA),
      .X_SPACING(XS), .SPRITE_COLORS(COLS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .pause(pause),
      .speed_sel(speed_sel), .display_on(display_on), .pix_x(pix_x), .pix_y(pix_y),
      .pix_rgb(pix_rgb), .busy(busy), .bounce_count(bounce_count)
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int comp(input int px, input int py, input bit de);
      logic [47:0] c;
      if (!de) return 0;
      c = COLS;
      for (int i = 0; i < N; i++)
         if (px >= mx[i] && px < mx[i] + SZ && py >= my[i] && py < my[i] + SZ)
            return int'((c >> (6 * i)) & 48'h3F);
      return 0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         mx[i]  = i * XS;
         my[i]  = i * 32;
         mdx[i] = 1;
         mdy[i] = (i % 2 == 1) ? -1 : 1;
      end
      mbounce = 0;
   endtask

   task automatic move(inout int p, inout int d, input int step, input int lim, output bit b);
      int n;
      b = 1'b0;
      n = (d > 0) ? p + step : p - step;
      if (d > 0 && n >= lim) begin p = lim; d = -1; b = 1'b1; end
      else if (d < 0 && n <= 0) begin p = 0; d = 1; b = 1'b1; end
      else p = n;
   endtask

   // Drive one pixel, push its expected colour, pop it when the output appears.
   task automatic probe(input int px, input int py, input bit de, input int exp, input string tag);
      pix_x      = 10'(px);
      pix_y      = 10'(py);
      display_on = de;
      exp_q.push_back(exp);
      @(posedge clk); #1;
      check_eq(tag, int'(pix_rgb), exp_q.pop_front());
   endtask

   task automatic probe_all();
      for (int i = 0; i < N; i++) begin
         if (mx[i] > 0) probe(mx[i] - 1, my[i], 1'b1, comp(mx[i] - 1, my[i], 1'b1), "edge_left");
         if (my[i] > 0) probe(mx[i], my[i] - 1, 1'b1, comp(mx[i], my[i] - 1, 1'b1), "edge_top");
         probe(mx[i], my[i], 1'b1, comp(mx[i], my[i], 1'b1), "corner_tl");
         probe(mx[i] + SZ - 1, my[i] + SZ - 1, 1'b1, comp(mx[i] + SZ - 1, my[i] + SZ - 1, 1'b1), "corner_br");
         probe(mx[i] + SZ, my[i] + SZ - 1, 1'b1, comp(mx[i] + SZ, my[i] + SZ - 1, 1'b1), "edge_right");
      end
   endtask

   // One accepted tick; s0 drives sprites 0-1, s1 sprites 2-3; extra injects a tick mid-sweep.
   task automatic run_tick(input logic [1:0] s0, input logic [1:0] s1, input bit extra);
      int n;
      bit bx, by;
      int sel;
      n          = 0;
      frame_tick = 1'b1;
      speed_sel  = s0;
      @(posedge clk); #1;
      frame_tick = 1'b0;
      while (busy && n < 20) begin
         speed_sel  = (n < 2) ? s0 : s1;
         frame_tick = extra && (n == 1);
         @(posedge clk); #1;
         n++;
      end
      frame_tick = 1'b0;
      check_eq("busy_len", n, N);
      for (int i = 0; i < N; i++) begin
         sel = (i < 2) ? int'(s0) : int'(s1);
         move(mx[i], mdx[i], (2 + i % 4) << sel, HA - SZ, bx);
         move(my[i], mdy[i], (1 + i % 3) << sel, VA - SZ, by);
         if (bx || by) mbounce = (mbounce + 1) % 256;
      end
      check_eq("bounce_count", int'(bounce_count), mbounce);
      @(posedge clk); #1;
      check_eq("busy_idle", int'(busy), 0);
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_bounce", int'(bounce_count), 0);
      check_eq("rst_rgb", int'(pix_rgb), 0);

      probe(10, 10, 1'b1, 6'b001100, "rst_s0_colour");
      probe(85, 40, 1'b1, 6'b110000, "rst_s1_colour");
      probe(70, 10, 1'b1, 0, "rst_gap");
      probe(10, 10, 1'b0, 0, "blank_forces_0");
      probe_all();

      // first sweep at speed_sel 0
      run_tick(2'd0, 2'd0, 1'b0);
      probe(2, 1, 1'b1, 6'b001100, "s0_moved_tl");
      probe(1, 1, 1'b1, 0, "s0_old_col");
      probe(83, 30, 1'b1, 6'b110000, "s1_moved_tl");
      probe(82, 30, 1'b1, 0, "s1_old_col");
      probe(83, 29, 1'b1, 0, "s1_old_row");
      probe_all();

      // pause drops the tick; compositing continues
      pause      = 1'b1;
      frame_tick = 1'b1;
      @(posedge clk); #1;
      frame_tick = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check_eq("pause_busy", int'(busy), 0);
         @(posedge clk); #1;
      end
      probe_all();
      pause = 1'b0;
      run_tick(2'd1, 2'd2, 1'b1);
      probe_all();

      // async reset in sweep cycle 2
      pix_x      = 10'd10;
      pix_y      = 10'd10;
      display_on = 1'b1;
      speed_sel  = 2'd0;
      frame_tick = 1'b1;
      @(posedge clk); #1;
      frame_tick = 1'b0;
      @(posedge clk); #1;
      check_eq("pre_rst_busy", int'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("async_busy", int'(busy), 0);
      check_eq("async_rgb", int'(pix_rgb), 0);
      check_eq("async_bounce", int'(bounce_count), 0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      probe_all();
      run_tick(2'd0, 2'd0, 1'b0);
      probe(2, 1, 1'b1, 6'b001100, "post_rst_s0");
      probe(83, 30, 1'b1, 6'b110000, "post_rst_s1");
      probe_all();

      // long run: walls, mid-sweep speed changes, counter wrap
      for (int t = 0; t < 600; t++) begin
         if (t < 300) run_tick(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), (t % 7) == 0);
         else         run_tick(2'd3, 2'd3, 1'b0);
         probe_all();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
